stream_upsizer: RTL and testbench
=================================

# stream_upsizer

Narrow-to-wide valid/ready stream width converter: packs SCALE consecutive DW_IN-bit input beats into one DW_IN*SCALE-bit output beat. It is the counterpart of stream_downsizer. The first accepted narrow beat lands in the least-significant lane, so a downsizer→upsizer chain is bit-exact. It sits between narrow producers (FIFO readers, serial front-ends) and wide datapaths or memories.

## Interface
- DW_IN, 16, width of one input beat
- SCALE, 3, input beats per output beat (≥1)
- DW_OUT, DW_IN*SCALE, derived; do not override
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_data_i  in  DW_IN  input beat
- s_valid_i  in  1  input valid
- s_ready_o  out  1  input ready
- m_data_o  out  DW_OUT  packed output word
- m_valid_o  out  1  output valid
- m_ready_i  in  1  output ready
- s_last_i  in  1  end of packet (only with STREAM_UPSIZER_LAST_EN)
- m_last_o  out  1  output word closes packet (only with STREAM_UPSIZER_LAST_EN)

## Operation
- Transfer occurs when valid && ready on the same rising edge; standard AXI-Stream rules. Once m_valid_o is asserted, m_data_o (and m_last_o, when present) hold stable until accepted.
- Lane counter cnt_r runs 0..SCALE-1 and is $clog2(SCALE) bits wide (minimum 1). Lane register lanes_r holds SCALE-1 lanes.
- Accepted beat with cnt_r < SCALE-1:
  - s_data_i is stored in lane cnt_r.
  - cnt_r increments.
- Accepted beat with cnt_r == SCALE-1:
  - m_data_o loads {s_data_i, lanes_r[SCALE-2:0]}: lane k sits in bits [DW_IN*k +: DW_IN].
  - m_valid_o is set and cnt_r returns to 0.
- Output register is separate from lanes_r, so lanes 0..SCALE-2 keep filling while an output word waits.
- s_ready_o = (cnt_r != SCALE-1) || !m_valid_o || m_ready_i. This is combinational from m_ready_i.
- m_valid_o clears on output handshake unless a new word loads on the same edge.
- SCALE==1: acts as a single-register pipeline stage.
- Reset mid-packet: the partial lane contents are discarded, with no flush.

## Timing
- Reset values: m_valid_o=0, m_data_o=0, cnt_r=0, lanes_r=0, m_last_o=0.
- s_ready_o=1 out of reset.
- Latency: the final beat accepted on edge N gives m_valid_o=1 after edge N.
- Throughput: one input beat per cycle sustained when m_ready_i=1, which is one output word per SCALE cycles.
- Simultaneous output accept and final-lane input on the same edge: the new word loads and m_valid_o stays 1, with no bubble.
- Output stalled with cnt_r==SCALE-1: s_ready_o=0 until m_ready_i.

## Configuration
- STREAM_UPSIZER_LAST_EN defined:
  - s_last_i and m_last_o ports exist.
  - An accepted beat with s_last_i=1 closes the word early regardless of cnt_r.
  - Lanes above the last are zero-filled, m_last_o=1, and cnt_r returns to 0.
  - s_ready_o also drops when s_last_i=1 and the output is occupied and not being accepted, i.e. the full-lane condition also holds when s_last_i is set. Ready may depend on s_last_i but never on s_valid_i.
- Undefined: no last ports; words are always complete.

## Structure
- Shared stream_utils_pkg holds a clog2-with-minimum-1 function, used by the upsizer and downsizer counter widths.
- No sub-module: the lane register, counter and output register are a single always block each.

## Test plan
All scenarios use DW_IN=16 and SCALE=3 unless stated.
- Full rate, m_ready_i=1: input beats 0x1111, 0x2222, 0x3333 → m_data_o=0x333322221111 with m_valid_o=1 one cycle after the third beat; s_ready_o never drops.
- Backpressure: m_ready_i=0 with two words offered → first word held stable; s_ready_o drops after lanes 0..1 of the second word fill. On m_ready_i=1 both words emerge in order.
- Loopback: 5461 random 48-bit words through stream_downsizer → stream_upsizer at write rate 0.3 and read rate 0.7 → all words match bit-exact.
- Reset mid-packet: assert rst after beats 0xAAAA and 0xBBBB → m_valid_o=0; the next three beats 0x1, 0x2, 0x3 give 0x000300020001.
- LAST_EN: beats 0xAAAA and 0xBBBB with s_last_i=1 on the second → m_data_o=0x0000BBBBAAAA, m_last_o=1; the next word starts at lane 0.
- SCALE=1: beats 0x5A5A then 0xA5A5 → each appears on m_data_o one cycle after acceptance.

Source files
------------

// File: rtl/stream_utils_pkg.sv
// Shared helpers for the stream width converters (upsizer/downsizer).
package stream_utils_pkg;

   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/stream_upsizer.sv
// stream_upsizer: packs SCALE narrow beats into one wide beat, lane 0 first.
// Optional packet framing (s_last_i / m_last_o) with `define STREAM_UPSIZER_LAST_EN.
`default_nettype none

module stream_upsizer
   import stream_utils_pkg::*;
#(
   parameter int DW_IN  = 16,
   parameter int SCALE  = 3,
   parameter int DW_OUT = DW_IN * SCALE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DW_IN-1:0]  s_data_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
`ifdef STREAM_UPSIZER_LAST_EN
   input  logic              s_last_i,
   output logic              m_last_o,
`endif
   output logic [DW_OUT-1:0] m_data_o,
   output logic              m_valid_o,
   input  logic              m_ready_i
);

   localparam int            CW      = clog2_min1(SCALE);
   localparam int            LANES_N = (SCALE > 1) ? SCALE - 1 : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCALE - 1);

   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [LANES_N-1:0][DW_IN-1:0] lanes_q, lanes_d;
   logic [DW_OUT-1:0]             data_q, data_d, word_w;
   logic                          valid_q, valid_d;
   logic                          last_w, full_w, accept_w, close_w;

`ifdef STREAM_UPSIZER_LAST_EN
   logic last_q;
   assign last_w   = s_last_i;
   assign m_last_o = last_q;
`else
   assign last_w   = 1'b0;
`endif

   // Closing beat needs the output register free (or freeing this edge).
   assign full_w    = (cnt_q == CNT_MAX) || last_w;
   assign s_ready_o = !full_w || !valid_q || m_ready_i;
   assign accept_w  = s_valid_i && s_ready_o;
   assign close_w   = accept_w && full_w;

   assign m_data_o  = data_q;
   assign m_valid_o = valid_q;

   always_comb begin
      word_w  = '0;
      lanes_d = lanes_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      data_d  = data_q;

      // Stale lanes at or above cnt_q are masked so early-closed words zero-fill.
      for (int k = 0; k < LANES_N; k++) begin
         if (CW'(k) < cnt_q) word_w[DW_IN*k +: DW_IN] = lanes_q[k];
      end
      for (int k = 0; k < SCALE; k++) begin
         if (CW'(k) == cnt_q) word_w[DW_IN*k +: DW_IN] = s_data_i;
      end

      if (accept_w && !close_w) begin
         for (int k = 0; k < LANES_N; k++) begin
            if (CW'(k) == cnt_q) lanes_d[k] = s_data_i;
         end
      end

      if (close_w) begin
         cnt_d = '0;
      end else if (accept_w) begin
         cnt_d = cnt_q + CW'(1);
      end

      if (close_w) begin
         valid_d = 1'b1;
         data_d  = word_w;
      end else if (m_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lanes_q <= '0;
      else     lanes_q <= lanes_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
`ifdef STREAM_UPSIZER_LAST_EN
         last_q  <= 1'b0;
`endif
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
`ifdef STREAM_UPSIZER_LAST_EN
         if (close_w) last_q <= last_w;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stream_upsizer.sv
// Randomized scoreboard bench for stream_upsizer (SCALE=3) plus a SCALE=1 instance.
module tb_stream_upsizer;

   localparam int DW_IN  = 16;
   localparam int SCALE  = 3;
   localparam int DW_OUT = DW_IN * SCALE;
`ifdef STREAM_UPSIZER_LAST_EN
   localparam bit LAST_EN = 1'b1;
`else
   localparam bit LAST_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [DW_IN-1:0]  s_data_i = '0;
   logic              s_valid_i = 1'b0;
   logic              s_ready_o;
   logic              s_last_i = 1'b0;
   logic              m_last_o;
   logic [DW_OUT-1:0] m_data_o;
   logic              m_valid_o;
   logic              m_ready_i = 1'b0;

   logic [DW_IN-1:0]  s1_data = '0;
   logic              s1_valid = 1'b0;
   logic              s1_ready;
   logic              m1_last;
   logic [DW_IN-1:0]  m1_data;
   logic              m1_valid;
   logic              m1_ready = 1'b0;

   stream_upsizer #(.DW_IN(DW_IN), .SCALE(SCALE)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .s_data_i  (s_data_i),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
`ifdef STREAM_UPSIZER_LAST_EN
      .s_last_i  (s_last_i),
      .m_last_o  (m_last_o),
`endif
      .m_data_o  (m_data_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i)
   );

   stream_upsizer #(.DW_IN(DW_IN), .SCALE(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .s_data_i  (s1_data),
      .s_valid_i (s1_valid),
      .s_ready_o (s1_ready),
`ifdef STREAM_UPSIZER_LAST_EN
      .s_last_i  (1'b0),
      .m_last_o  (m1_last),
`endif
      .m_data_o  (m1_data),
      .m_valid_o (m1_valid),
      .m_ready_i (m1_ready)
   );

   typedef struct packed {
      logic [DW_OUT-1:0] data;
      logic              last;
   } exp_t;

   exp_t             exp_q[$];
   logic [DW_IN-1:0] part[$];
   int               n_chk = 0;
   int               n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: collect beats; a word closes after SCALE beats or on last.
   function automatic void model_accept(input logic [DW_IN-1:0] d, input logic l);
      exp_t e;
      part.push_back(d);
      if (part.size() == SCALE || (LAST_EN && l)) begin
         e.data = '0;
         for (int i = 0; i < part.size(); i++) e.data[DW_IN*i +: DW_IN] = part[i];
         e.last = LAST_EN && l;
         exp_q.push_back(e);
         part.delete();
      end
   endfunction

   // Monitor: output register must be valid exactly while a word is owed.
   initial begin
      exp_t              e;
      logic              hold = 1'b0;
      logic [DW_OUT-1:0] held;
      forever begin
         @(posedge clk);
         #3;
         chk("m_valid", m_valid_o, exp_q.size() != 0);
         if (hold) chk("m_data_stable", m_data_o, held);
         hold = m_valid_o && !m_ready_i;
         held = m_data_o;
         if (m_valid_o && m_ready_i && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("m_data", m_data_o, e.data);
`ifdef STREAM_UPSIZER_LAST_EN
            chk("m_last", m_last_o, e.last);
`endif
         end
      end
   end

   // One cycle: drive, check ready against the model, record the transfer.
   task automatic step(input logic v, input logic [DW_IN-1:0] d, input logic l,
                       input logic r, output logic acc);
      logic exp_rdy;
      @(posedge clk);
      #1;
      s_valid_i = v;
      s_data_i  = d;
      s_last_i  = l;
      m_ready_i = r;
      #1;
      exp_rdy = (part.size() != SCALE - 1 && !(LAST_EN && l)) || exp_q.size() == 0 || r;
      chk("s_ready", s_ready_o, exp_rdy);
      acc = v && s_ready_o;
      #2;
      if (acc) model_accept(d, l);
   endtask

   task automatic send_beat(input logic [DW_IN-1:0] d, input logic l, input logic r);
      logic acc;
      for (int i = 0; i < 50; i++) begin
         step(1'b1, d, l, r, acc);
         if (acc) return;
      end
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
   endtask

   task automatic idle(input int n, input logic r);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, r, acc);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      s_valid_i = 1'b0;
      m_ready_i = 1'b0;
      part.delete();
      exp_q.delete();
      #1;
      chk("rst_m_valid", m_valid_o, 0);
      chk("rst_m_data", m_data_o, 0);
      chk("rst_s_ready", s_ready_o, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic             acc, v, l, r, pending;
      logic [DW_IN-1:0] d;
      int               pv[4] = '{100, 30, 100, 70};
      int               pr[4] = '{100, 70, 20, 30};

      do_reset();

      // Full rate
      send_beat(16'h1111, 1'b0, 1'b1);
      send_beat(16'h2222, 1'b0, 1'b1);
      send_beat(16'h3333, 1'b0, 1'b1);
      idle(3, 1'b1);

      // Backpressure: two words offered while the sink stalls
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, acc);
         while (!acc) step(1'b1, 16'(16'h0100 + i), 1'b0, (i == 5) ? 1'b1 : 1'b0, acc);
         if (i == 4) idle(3, 1'b0);
      end
      idle(4, 1'b1);

      // Reset mid-packet discards partial lanes
      send_beat(16'hAAAA, 1'b0, 1'b1);
      send_beat(16'hBBBB, 1'b0, 1'b1);
      do_reset();
      send_beat(16'h0001, 1'b0, 1'b1);
      send_beat(16'h0002, 1'b0, 1'b1);
      send_beat(16'h0003, 1'b0, 1'b1);
      idle(3, 1'b1);

`ifdef STREAM_UPSIZER_LAST_EN
      send_beat(16'hAAAA, 1'b0, 1'b1);
      send_beat(16'hBBBB, 1'b1, 1'b1);
      send_beat(16'h0001, 1'b0, 1'b1);
      send_beat(16'h0002, 1'b0, 1'b1);
      send_beat(16'h0003, 1'b0, 1'b1);
      idle(3, 1'b1);
`endif

      // Randomized traffic in several rate phases
      pending = 1'b0;
      v = 1'b0;
      l = 1'b0;
      d = '0;
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 300; c++) begin
            if (!pending) begin
               d = DW_IN'($urandom);
               l = ($urandom_range(0, 7) == 0);
               v = ($urandom_range(0, 99) < pv[p]);
            end
            r = ($urandom_range(0, 99) < pr[p]);
            step(v, d, l, r, acc);
            pending = v && !acc;
         end
      end
      while (pending) begin
         step(1'b1, d, l, 1'b1, acc);
         pending = !acc;
      end
      idle(6, 1'b1);
      chk("drain_empty", exp_q.size(), 0);

      // SCALE=1 behaves as a single register stage
      @(posedge clk);
      #1;
      s1_valid = 1'b1;
      s1_data  = 16'h5A5A;
      m1_ready = 1'b1;
      #1;
      chk("s1_ready", s1_ready, 1);
      @(posedge clk);
      #1;
      s1_data = 16'hA5A5;
      #1;
      chk("s1_valid_a", m1_valid, 1);
      chk("s1_data_a", m1_data, 16'h5A5A);
      @(posedge clk);
      #1;
      s1_valid = 1'b0;
      #1;
      chk("s1_valid_b", m1_valid, 1);
      chk("s1_data_b", m1_data, 16'hA5A5);
      @(posedge clk);
      #2;
      chk("s1_valid_c", m1_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
